// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch opcodes, resolve FSM states and the conditional-branch target helper.
// Opcode values 12..15 are unassigned and resolve as not-taken.
package branch_resolve_unit_pkg;

  localparam logic [3:0] BR_BEQ  = 4'd0;
  localparam logic [3:0] BR_BNE  = 4'd1;
  localparam logic [3:0] BR_BLEZ = 4'd2;
  localparam logic [3:0] BR_BGTZ = 4'd3;
  localparam logic [3:0] BR_BLTZ = 4'd4;
  localparam logic [3:0] BR_BGEZ = 4'd5;
  localparam logic [3:0] BR_BGTU = 4'd6;
  localparam logic [3:0] BR_BLTU = 4'd7;
  localparam logic [3:0] BR_J    = 4'd8;
  localparam logic [3:0] BR_JAL  = 4'd9;
  localparam logic [3:0] BR_JR   = 4'd10;
  localparam logic [3:0] BR_JALR = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PEND  = 2'd2
  } br_state_t;

  // pc + 4 + word offset, wrapping mod 2^32
  function automatic logic [31:0] br_target(input logic [31:0] pc, input logic [15:0] imm);
    br_target = pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_resolve_unit_sat_counter.sv
// Saturating event counter: +1 per cycle with inc, sticks at all-ones; clr beats inc.
// Latency 1, no backpressure.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves ID-stage branches/jumps into a registered PC redirect plus IF flush, one cycle after resolve.
// Backpressure: when pc_en is low the redirect is held (PEND, busy=1) until the PC register accepts it.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             br_valid,
  input  logic [3:0]       br_op,
  input  logic [31:0]      pc_id,
  input  logic [15:0]      imm16,
  input  logic [25:0]      jidx26,
  input  logic [31:0]      rs_val,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  input  logic             a_sign,
  input  logic             stall_id,
  input  logic             pc_en,
  input  logic             stat_clr,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic             flush_if,
  output logic             busy,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  br_state_t   state;
  logic        taken;
  logic [31:0] target;
  logic        resolve;

  // Branches arriving while a redirect is outstanding sit in the delay slot and are never resolved.
  assign resolve = br_valid && !stall_id && (state == ST_IDLE);

  always_comb begin
    taken  = 1'b0;
    target = br_target(pc_id, imm16);
    case (br_op)
      BR_BEQ:  taken = cmp_eq;
      BR_BNE:  taken = !cmp_eq;
      BR_BLEZ: taken = a_sign || cmp_eq;
      BR_BGTZ: taken = !a_sign && !cmp_eq;
      BR_BLTZ: taken = a_sign;
      BR_BGEZ: taken = !a_sign;
      BR_BGTU: taken = cmp_gt;
      BR_BLTU: taken = cmp_lt;
      BR_J, BR_JAL: begin
        taken  = 1'b1;
        target = {pc_id[31:28], jidx26, 2'b00};
      end
      BR_JR, BR_JALR: begin
        taken  = 1'b1;
        target = rs_val;
      end
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      redirect    <= 1'b0;
      flush_if    <= 1'b0;
      busy        <= 1'b0;
      redirect_pc <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (resolve && taken) begin
            state       <= ST_ARMED;
            redirect    <= 1'b1;
            flush_if    <= 1'b1;
            redirect_pc <= target;
          end
        end
        ST_ARMED, ST_PEND: begin
          if (pc_en) begin
            state       <= ST_IDLE;
            redirect    <= 1'b0;
            flush_if    <= 1'b0;
            busy        <= 1'b0;
            redirect_pc <= 32'd0;
          end else begin
            state <= ST_PEND;
            busy  <= 1'b1;
          end
        end
        default: begin
          state       <= ST_IDLE;
          redirect    <= 1'b0;
          flush_if    <= 1'b0;
          busy        <= 1'b0;
          redirect_pc <= 32'd0;
        end
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (resolve),
    .clr     (stat_clr),
    .cnt     (br_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (resolve && taken),
    .clr     (stat_clr),
    .cnt     (taken_cnt)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench: expected redirect cycles are queued by stimulus, a negedge monitor pops and checks them.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             br_valid, cmp_eq, cmp_gt, cmp_lt, a_sign, stall_id, pc_en, stat_clr;
  logic [3:0]       br_op;
  logic [31:0]      pc_id, rs_val, redirect_pc;
  logic [15:0]      imm16;
  logic [25:0]      jidx26;
  logic             redirect, flush_if, busy;
  logic [CNT_W-1:0] br_cnt, taken_cnt;

  typedef struct {
    logic [31:0] pc;
    logic        busy;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .br_valid    (br_valid),
    .br_op       (br_op),
    .pc_id       (pc_id),
    .imm16       (imm16),
    .jidx26      (jidx26),
    .rs_val      (rs_val),
    .cmp_eq      (cmp_eq),
    .cmp_gt      (cmp_gt),
    .cmp_lt      (cmp_lt),
    .a_sign      (a_sign),
    .stall_id    (stall_id),
    .pc_en       (pc_en),
    .stat_clr    (stat_clr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .flush_if    (flush_if),
    .busy        (busy),
    .br_cnt      (br_cnt),
    .taken_cnt   (taken_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic b);
    exp_t e;
    e.pc   = pc;
    e.busy = b;
    q.push_back(e);
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] pc, input logic [15:0] imm,
                       input logic [25:0] jidx, input logic eq, input logic sgn);
    br_valid = 1'b1;
    br_op    = op;
    pc_id    = pc;
    imm16    = imm;
    jidx26   = jidx;
    cmp_eq   = eq;
    a_sign   = sgn;
  endtask

  task automatic clear_stats();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("clr_br_cnt", 32'(br_cnt), 0);
    chk("clr_taken_cnt", 32'(taken_cnt), 0);
  endtask

  // Monitor: every redirect cycle must match the head of the expected queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("flush_tracks_redirect", 32'(flush_if), 32'(redirect));
        if (redirect) begin
          if (q.size() == 0) begin
            chk("unexpected_redirect", 32'(redirect), 0);
          end else begin
            e = q.pop_front();
            chk("redirect_pc", redirect_pc, e.pc);
            chk("busy", 32'(busy), 32'(e.busy));
          end
        end else begin
          chk("busy_without_redirect", 32'(busy), 0);
        end
      end
    end
  end

  initial begin
    reset_n  = 1'b0;
    br_valid = 1'b0; br_op = BR_BEQ; pc_id = 32'd0; imm16 = 16'd0; jidx26 = 26'd0;
    rs_val   = 32'd0; cmp_eq = 1'b0; cmp_gt = 1'b0; cmp_lt = 1'b0; a_sign = 1'b0;
    stall_id = 1'b0; pc_en = 1'b1; stat_clr = 1'b0;
    #2;
    chk("rst_redirect", 32'(redirect), 0);
    chk("rst_flush", 32'(flush_if), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pc", redirect_pc, 0);
    chk("rst_br_cnt", 32'(br_cnt), 0);
    chk("rst_taken_cnt", 32'(taken_cnt), 0);
    step(); step();
    reset_n = 1'b1;
    step();

    // 1: BEQ taken, target 0x3000+4+16
    clear_stats();
    issue(BR_BEQ, 32'h3000, 16'h0004, 26'd0, 1'b1, 1'b0);
    push(32'h3014, 1'b0);
    step();
    br_valid = 1'b0;
    chk("t1_br_cnt", 32'(br_cnt), 1);
    chk("t1_taken_cnt", 32'(taken_cnt), 1);
    step();
    chk("t1_redirect_low", 32'(redirect), 0);
    chk("t1_flush_low", 32'(flush_if), 0);
    chk("t1_pc_low", redirect_pc, 0);

    // 2: BNE with equal operands, then an unassigned opcode: counted, never taken
    clear_stats();
    issue(BR_BNE, 32'h3000, 16'h0004, 26'd0, 1'b1, 1'b0);
    step();
    br_valid = 1'b0;
    step();
    issue(4'd14, 32'h3000, 16'h0004, 26'd0, 1'b1, 1'b1);
    step();
    br_valid = 1'b0;
    step();
    chk("t2_br_cnt", 32'(br_cnt), 2);
    chk("t2_taken_cnt", 32'(taken_cnt), 0);

    // 3: BGEZ held by stall for 3 cycles; target 0x3010+4-4
    clear_stats();
    issue(BR_BGEZ, 32'h3010, 16'hFFFF, 26'd0, 1'b0, 1'b0);
    stall_id = 1'b1;
    repeat (3) step();
    chk("t3_no_count_while_stalled", 32'(br_cnt), 0);
    stall_id = 1'b0;
    push(32'h3010, 1'b0);
    step();
    br_valid = 1'b0;
    chk("t3_br_cnt", 32'(br_cnt), 1);
    step();

    // 4: J held by pc_en low -> ARMED, PEND, PEND; br_valid while busy is ignored
    clear_stats();
    issue(BR_J, 32'hB000_0000, 16'd0, 26'h3FF_FFFF, 1'b0, 1'b0);
    pc_en = 1'b0;
    push(32'hBFFF_FFFC, 1'b0);
    push(32'hBFFF_FFFC, 1'b1);
    push(32'hBFFF_FFFC, 1'b1);
    step();
    issue(BR_BEQ, 32'h4000, 16'h0001, 26'd0, 1'b1, 1'b0);
    step();
    chk("t4_busy_pend", 32'(busy), 1);
    step();
    pc_en    = 1'b1;
    br_valid = 1'b0;
    step();
    chk("t4_busy_released", 32'(busy), 0);
    chk("t4_br_cnt", 32'(br_cnt), 1);
    chk("t4_taken_cnt", 32'(taken_cnt), 1);

    // 5: 17 taken branches saturate a 4-bit counter; clear beats a same-cycle resolve
    clear_stats();
    for (int i = 0; i < 17; i++) begin
      issue(BR_BEQ, 32'h100, 16'h0000, 26'd0, 1'b1, 1'b0);
      push(32'h104, 1'b0);
      step();
      br_valid = 1'b0;
      step();
    end
    chk("t5_taken_sat", 32'(taken_cnt), 15);
    chk("t5_br_sat", 32'(br_cnt), 15);
    issue(BR_BEQ, 32'h100, 16'h0000, 26'd0, 1'b1, 1'b0);
    stat_clr = 1'b1;
    push(32'h104, 1'b0);
    step();
    stat_clr = 1'b0;
    br_valid = 1'b0;
    chk("t5_clr_br", 32'(br_cnt), 0);
    chk("t5_clr_taken", 32'(taken_cnt), 0);
    step();

    // 6: asynchronous reset while PEND drops everything immediately
    issue(BR_J, 32'h0, 16'd0, 26'd1, 1'b0, 1'b0);
    pc_en = 1'b0;
    push(32'h4, 1'b0);
    push(32'h4, 1'b1);
    step();
    br_valid = 1'b0;
    step();
    #5;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_redirect", 32'(redirect), 0);
    chk("t6_rst_flush", 32'(flush_if), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_pc", redirect_pc, 0);
    chk("t6_rst_br_cnt", 32'(br_cnt), 0);
    step();
    reset_n = 1'b1;
    pc_en   = 1'b1;
    step();
    issue(BR_BEQ, 32'h200, 16'h0002, 26'd0, 1'b1, 1'b0);
    push(32'h20C, 1'b0);
    step();
    br_valid = 1'b0;
    chk("t6_br_cnt", 32'(br_cnt), 1);
    chk("t6_taken_cnt", 32'(taken_cnt), 1);
    step();
    step();

    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
